// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: fetch FSM states, the NOP
// encoding, the PC increment, the default reset PC and a PC helper.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    // Sequential PC; 32-bit unsigned arithmetic wraps naturally.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        pc_next = pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus: one valid/ready request channel and a response
// channel without back-pressure. master = fetch unit, slave = memory.
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry hold buffer used when a fetch
// response arrives while decode is stalled on a valid entry.
// Optional build macro IFETCH_ALIGN_CHECK_EN adds a misalign flag to entries.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic        park,
    input  logic        unpark,
    input  logic        stall,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
`ifdef IFETCH_ALIGN_CHECK_EN
    input  logic        in_misalign,
    output logic        if_misalign,
`endif
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    logic        hold_valid_r;
    logic [31:0] hold_instr_r;
    logic [31:0] hold_pc_r;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        hold_misalign_r;
`endif

    // IF/ID slot: flush beats load, load beats unpark, otherwise consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid    <= 1'b0;
            if_instr    <= MIPS_NOP;
            if_pc       <= RESET_PC;
            if_pc_plus4 <= pc_next(RESET_PC);
`ifdef IFETCH_ALIGN_CHECK_EN
            if_misalign <= 1'b0;
`endif
        end else if (flush) begin
            if_valid    <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            if_misalign <= 1'b0;
`endif
        end else if (load) begin
            if_valid    <= 1'b1;
            if_instr    <= in_instr;
            if_pc       <= in_pc;
            if_pc_plus4 <= pc_next(in_pc);
`ifdef IFETCH_ALIGN_CHECK_EN
            if_misalign <= in_misalign;
`endif
        end else if (unpark && hold_valid_r) begin
            if_valid    <= 1'b1;
            if_instr    <= hold_instr_r;
            if_pc       <= hold_pc_r;
            if_pc_plus4 <= pc_next(hold_pc_r);
`ifdef IFETCH_ALIGN_CHECK_EN
            if_misalign <= hold_misalign_r;
`endif
        end else if (if_valid && !stall) begin
            if_valid    <= 1'b0;
        end
    end

    // Hold buffer: parks one response while the slot is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_r    <= 1'b0;
            hold_instr_r    <= MIPS_NOP;
            hold_pc_r       <= RESET_PC;
`ifdef IFETCH_ALIGN_CHECK_EN
            hold_misalign_r <= 1'b0;
`endif
        end else if (flush) begin
            hold_valid_r    <= 1'b0;
        end else if (park) begin
            hold_valid_r    <= 1'b1;
            hold_instr_r    <= in_instr;
            hold_pc_r       <= in_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
            hold_misalign_r <= in_misalign;
`endif
        end else if (unpark) begin
            hold_valid_r    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, issues one imem request at a
// time, fills the IF/ID register, honours decode stall and execute redirect.
// Optional build macro IFETCH_ALIGN_CHECK_EN: misaligned PCs are not fetched;
// a NOP flagged if_misalign is delivered and fetch halts until a redirect.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master imem,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         stall,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic         if_misalign,
`endif
    output logic         if_valid,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_pc_plus4
);

    fetch_state_e state_r, state_n;
    logic [31:0]  pc_r, pc_n;
    logic [31:0]  pc_out_r, pc_out_n;
    logic         drop_r, drop_n;
    logic         req_valid_s;
    logic         handshake_s;
    logic         outstanding_s;
    logic         slot_free_s;
    logic         load_s, park_s, unpark_s, flush_s;
    logic [31:0]  ld_instr_s, ld_pc_s;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic         halt_r, halt_n;
    logic         ld_misalign_s;
`endif

    // Without the alignment check the low PC bits are simply cleared.
    function automatic logic [31:0] pc_align(input logic [31:0] pc);
`ifdef IFETCH_ALIGN_CHECK_EN
        pc_align = pc;
`else
        pc_align = pc & PC_ALIGN_MASK;
`endif
    endfunction

    // A request is only offered when nothing is in flight, so a redirect
    // that leaves a stale response pending drains it in S_REQ first.
`ifdef IFETCH_ALIGN_CHECK_EN
    assign req_valid_s = (state_r == S_REQ) && !drop_r && !halt_r && (pc_r[1:0] == 2'b00);
`else
    assign req_valid_s = (state_r == S_REQ) && !drop_r;
`endif
    assign handshake_s   = req_valid_s && imem.imem_req_ready;
    assign outstanding_s = (state_r == S_WAIT) || ((state_r == S_REQ) && drop_r);
    assign slot_free_s   = !if_valid || !stall;

    assign imem.imem_req_valid = req_valid_s;
    assign imem.imem_addr      = pc_r;

    // Next-state, PC update and IF/ID control; redirect overrides everything.
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        pc_out_n   = pc_out_r;
        drop_n     = drop_r;
        load_s     = 1'b0;
        park_s     = 1'b0;
        unpark_s   = 1'b0;
        flush_s    = 1'b0;
        ld_instr_s = imem.imem_rsp_data;
        ld_pc_s    = pc_out_r;
`ifdef IFETCH_ALIGN_CHECK_EN
        halt_n        = halt_r;
        ld_misalign_s = 1'b0;
`endif
        if (redirect_valid && (state_r != S_IDLE)) begin
            pc_n    = pc_align(redirect_pc);
            flush_s = 1'b1;
            state_n = S_REQ;
            drop_n  = (outstanding_s && !imem.imem_rsp_valid) || handshake_s;
`ifdef IFETCH_ALIGN_CHECK_EN
            halt_n  = 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_n = S_REQ;
                end
                S_REQ: begin
                    if (drop_r) begin
                        drop_n = !imem.imem_rsp_valid;
                    end else if (handshake_s) begin
                        pc_out_n = pc_r;
                        state_n  = S_WAIT;
`ifdef IFETCH_ALIGN_CHECK_EN
                    end else if (!halt_r && (pc_r[1:0] != 2'b00) && slot_free_s) begin
                        load_s        = 1'b1;
                        ld_instr_s    = MIPS_NOP;
                        ld_pc_s       = pc_r;
                        ld_misalign_s = 1'b1;
                        halt_n        = 1'b1;
`endif
                    end else begin
                        state_n = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (drop_r) begin
                            drop_n  = 1'b0;
                            state_n = S_REQ;
                        end else if (slot_free_s) begin
                            load_s  = 1'b1;
                            pc_n    = pc_align(pc_next(pc_out_r));
                            state_n = S_REQ;
                        end else begin
                            park_s  = 1'b1;
                            pc_n    = pc_align(pc_next(pc_out_r));
                            state_n = S_HOLD;
                        end
                    end else begin
                        state_n = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (slot_free_s) begin
                        unpark_s = 1'b1;
                        state_n  = S_REQ;
                    end else begin
                        state_n  = S_HOLD;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // State, PC, accepted-address and drop-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            pc_r     <= pc_align(RESET_PC);
            pc_out_r <= pc_align(RESET_PC);
            drop_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            pc_r     <= pc_n;
            pc_out_r <= pc_out_n;
            drop_r   <= drop_n;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Misalign halt flag; cleared only by a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_r <= 1'b0;
        end else begin
            halt_r <= halt_n;
        end
    end
`endif

    if_id_reg #(
        .RESET_PC    (RESET_PC)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush_s),
        .load        (load_s),
        .park        (park_s),
        .unpark      (unpark_s),
        .stall       (stall),
        .in_instr    (ld_instr_s),
        .in_pc       (ld_pc_s),
`ifdef IFETCH_ALIGN_CHECK_EN
        .in_misalign (ld_misalign_s),
        .if_misalign (if_misalign),
`endif
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for fetch, stall,
// redirect and ready back-pressure, hand sequences for redirect corners,
// and a second instance reset at 32'hFFFF_FFFC for PC wrap.
// Honours build macro IFETCH_ALIGN_CHECK_EN.
module tb_fetch_unit;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic        w_if_valid;
    logic [31:0] w_if_instr, w_if_pc, w_if_pc_plus4;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        if_misalign;
    logic        w_if_misalign;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    fetch_unit_if bus ();
    fetch_unit_if bus_w ();

    fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
`ifdef IFETCH_ALIGN_CHECK_EN
        .if_misalign    (if_misalign),
`endif
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus_w.master),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .stall          (1'b0),
`ifdef IFETCH_ALIGN_CHECK_EN
        .if_misalign    (w_if_misalign),
`endif
        .if_valid       (w_if_valid),
        .if_instr       (w_if_instr),
        .if_pc          (w_if_pc),
        .if_pc_plus4    (w_if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word stored at an address in the memory model.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Main memory model: programmable extra latency, counts accepts/overlaps.
    int          mem_lat;
    logic        pend_r;
    int          cnt_r;
    logic [31:0] paddr_r;
    int          acc404;
    int          acc_total;
    int          overlap_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= 32'h0;
            pend_r      <= 1'b0;
            cnt_r       <= 0;
            paddr_r     <= 32'h0;
            acc404      <= 0;
            acc_total   <= 0;
            overlap_cnt <= 0;
        end else begin
            bus.imem_rsp_valid <= 1'b0;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                acc_total <= acc_total + 1;
                if (pend_r || bus.imem_rsp_valid) overlap_cnt <= overlap_cnt + 1;
                if (bus.imem_addr == 32'h0000_0404) acc404 <= acc404 + 1;
                if (mem_lat == 0) begin
                    bus.imem_rsp_valid <= 1'b1;
                    bus.imem_rsp_data  <= word(bus.imem_addr);
                end else begin
                    pend_r  <= 1'b1;
                    paddr_r <= bus.imem_addr;
                    cnt_r   <= mem_lat - 1;
                end
            end else if (pend_r) begin
                if (cnt_r == 0) begin
                    bus.imem_rsp_valid <= 1'b1;
                    bus.imem_rsp_data  <= word(paddr_r);
                    pend_r <= 1'b0;
                end else begin
                    cnt_r <= cnt_r - 1;
                end
            end
        end
    end

    // Wrap-instance memory: always ready, one-cycle response, logs first two addresses.
    int          w_n;
    logic [31:0] w_acc0, w_acc1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_w.imem_rsp_valid <= 1'b0;
            bus_w.imem_rsp_data  <= 32'h0;
            w_n    <= 0;
            w_acc0 <= 32'hDEAD_BEEF;
            w_acc1 <= 32'hDEAD_BEEF;
        end else begin
            bus_w.imem_rsp_valid <= bus_w.imem_req_valid && bus_w.imem_req_ready;
            bus_w.imem_rsp_data  <= word(bus_w.imem_addr);
            if (bus_w.imem_req_valid && bus_w.imem_req_ready) begin
                if (w_n == 0) w_acc0 <= bus_w.imem_addr;
                if (w_n == 1) w_acc1 <= bus_w.imem_addr;
                w_n <= w_n + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bounded wait at negedges: which 0 = if_valid, 1 = req_valid, 2 = rsp_valid.
    task automatic wait_for(input int which, input int max, input string nm);
        int  k;
        logic hit;
        k = 0;
        hit = 1'b0;
        while (k < max) begin
            case (which)
                0:       hit = if_valid;
                1:       hit = bus.imem_req_valid;
                default: hit = bus.imem_rsp_valid;
            endcase
            if (hit) break;
            @(negedge clk);
            k++;
        end
        chk(nm, {31'd0, hit}, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        rdr;
        logic [31:0] rdr_pc;
        logic        ready;
        int          lat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mkv(input logic s, input logic r, input logic [31:0] rp,
                                 input logic rdy, input int lat, input logic eq,
                                 input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.rdr = r; v.rdr_pc = rp; v.ready = rdy; v.lat = lat;
        v.e_req = eq; v.e_addr = ea; v.e_ifv = ev; v.e_pc = ep;
        return v;
    endfunction

    initial begin
        //               stall rdr rdr_pc        rdy lat | req addr           ifv pc
        tbl[0]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h000, 1'b0, 32'h000);
        tbl[1]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 32'h000, 1'b0, 32'h000);
        tbl[2]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h000, 1'b0, 32'h000);
        tbl[3]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 32'h004, 1'b1, 32'h000);
        tbl[4]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h004, 1'b0, 32'h000);
        tbl[5]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 32'h008, 1'b1, 32'h004);
        tbl[6]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h008, 1'b0, 32'h004);
        tbl[7]  = mkv(1'b1, 1'b0, 32'h0,   1'b1, 0, 1'b1, 32'h00C, 1'b1, 32'h008);
        tbl[8]  = mkv(1'b1, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h00C, 1'b1, 32'h008);
        tbl[9]  = mkv(1'b1, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h010, 1'b1, 32'h008);
        tbl[10] = mkv(1'b1, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h010, 1'b1, 32'h008);
        tbl[11] = mkv(1'b1, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h010, 1'b1, 32'h008);
        tbl[12] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h010, 1'b1, 32'h008);
        tbl[13] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 32'h010, 1'b1, 32'h00C);
        tbl[14] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h010, 1'b0, 32'h00C);
        tbl[15] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 2, 1'b1, 32'h014, 1'b1, 32'h010);
        tbl[16] = mkv(1'b0, 1'b1, 32'h400, 1'b1, 2, 1'b0, 32'h014, 1'b0, 32'h010);
        tbl[17] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h400, 1'b0, 32'h010);
        tbl[18] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h400, 1'b0, 32'h010);
        tbl[19] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 32'h400, 1'b0, 32'h010);
        tbl[20] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h400, 1'b0, 32'h010);
        tbl[21] = mkv(1'b0, 1'b0, 32'h0,   1'b0, 0, 1'b1, 32'h404, 1'b1, 32'h400);
        tbl[22] = mkv(1'b0, 1'b0, 32'h0,   1'b0, 0, 1'b1, 32'h404, 1'b0, 32'h400);
        tbl[23] = mkv(1'b0, 1'b0, 32'h0,   1'b0, 0, 1'b1, 32'h404, 1'b0, 32'h400);
        tbl[24] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 32'h404, 1'b0, 32'h400);
        tbl[25] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h404, 1'b0, 32'h400);
        tbl[26] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 32'h408, 1'b1, 32'h404);

        rst_n              = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        stall              = 1'b0;
        mem_lat            = 0;
        bus.imem_req_ready = 1'b1;
        bus_w.imem_req_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst if_valid",    {31'd0, if_valid}, 32'd0);
        chk("rst if_instr",    if_instr, MIPS_NOP);
        chk("rst if_pc",       if_pc, 32'h0);
        chk("rst if_pc_plus4", if_pc_plus4, 32'h4);
        chk("rst req_valid",   {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst imem_addr",   bus.imem_addr, 32'h0);
        chk("rst wrap plus4",  w_if_pc_plus4, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("c%0d req_valid", i), {31'd0, bus.imem_req_valid}, {31'd0, tbl[i].e_req});
            chk($sformatf("c%0d imem_addr", i), bus.imem_addr, tbl[i].e_addr);
            chk($sformatf("c%0d if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_ifv});
            chk($sformatf("c%0d if_pc", i), if_pc, tbl[i].e_pc);
            chk($sformatf("c%0d if_pc_plus4", i), if_pc_plus4, tbl[i].e_pc + 32'd4);
            if (tbl[i].e_ifv) chk($sformatf("c%0d if_instr", i), if_instr, word(tbl[i].e_pc));
            if (i == 3) begin
                chk("wrap if_valid", {31'd0, w_if_valid}, 32'd1);
                chk("wrap if_pc", w_if_pc, 32'hFFFF_FFFC);
                chk("wrap if_pc_plus4", w_if_pc_plus4, 32'h0);
            end
            stall              = tbl[i].stall;
            redirect_valid     = tbl[i].rdr;
            redirect_pc        = tbl[i].rdr_pc;
            bus.imem_req_ready = tbl[i].ready;
            mem_lat            = tbl[i].lat;
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        chk("accepts of 0x404", acc404, 32'd1);
        chk("wrap first addr", w_acc0, 32'hFFFF_FFFC);
        chk("wrap second addr", w_acc1, 32'h0);

        // Redirect while stalled on a valid entry: slot must flush anyway.
        stall = 1'b1;
        wait_for(0, 20, "stall fill timeout");
        do_redirect(32'h800);
        chk("rdr+stall flush", {31'd0, if_valid}, 32'd0);
        stall = 1'b0;
        wait_for(0, 20, "0x800 timeout");
        chk("0x800 if_pc", if_pc, 32'h800);
        chk("0x800 if_instr", if_instr, word(32'h800));

        // Redirect in the cycle a request is accepted: stale reply must not land.
        wait_for(1, 20, "req timeout");
        do_redirect(32'hC00);
        chk("rdr@hs no new req", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rdr@hs if_valid", {31'd0, if_valid}, 32'd0);
        wait_for(0, 20, "0xC00 timeout");
        chk("0xC00 if_pc", if_pc, 32'hC00);
        chk("0xC00 if_instr", if_instr, word(32'hC00));

        // Redirect in the cycle the response arrives: response discarded.
        wait_for(2, 20, "rsp timeout");
        do_redirect(32'hE00);
        chk("rdr@rsp req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("rdr@rsp imem_addr", bus.imem_addr, 32'hE00);
        chk("rdr@rsp if_valid", {31'd0, if_valid}, 32'd0);
        wait_for(0, 20, "0xE00 timeout");
        chk("0xE00 if_pc", if_pc, 32'hE00);
        chk("0xE00 if_instr", if_instr, word(32'hE00));

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned redirect: NOP flagged, no request, halt until redirect.
        do_redirect(32'h102);
        wait_for(0, 20, "misalign timeout");
        chk("mis if_misalign", {31'd0, if_misalign}, 32'd1);
        chk("mis if_instr", if_instr, MIPS_NOP);
        chk("mis if_pc", if_pc, 32'h102);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mis halt req %0d", k), {31'd0, bus.imem_req_valid}, 32'd0);
        end
        do_redirect(32'h200);
        wait_for(0, 20, "0x200 timeout");
        chk("0x200 if_pc", if_pc, 32'h200);
        chk("0x200 if_misalign", {31'd0, if_misalign}, 32'd0);
        chk("0x200 if_instr", if_instr, word(32'h200));
`else
        // Misaligned redirect: low PC bits are cleared.
        do_redirect(32'h102);
        chk("align imem_addr", bus.imem_addr, 32'h100);
        wait_for(0, 20, "0x100 timeout");
        chk("align if_pc", if_pc, 32'h100);
        chk("align if_pc_plus4", if_pc_plus4, 32'h104);
`endif

        chk("no request overlap", overlap_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
